// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//   MEM-stage sequencer for a multi-cycle data memory. Decodes the load/store
//   held in EX/MEM and runs a req/gnt/rvalid handshake. While the access is in
//   flight it freezes the front of the pipeline and bubbles MEM/WB.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   ResultSrcM, MemWriteM    EX/MEM decode (2'b01 = load, MemWriteM = store)
//   ALURESULTM, WriteDataM   effective address and store data from EX/MEM
//   dmem_req/we/addr/wdata   request channel to data memory (latched values)
//   dmem_gnt                 memory accepts the request this cycle
//   dmem_rvalid/rdata        load response
//   ReadDataM                captured load data towards MEM/WB
//   StallMem                 hold PC, IF/ID, ID/EX and EX/MEM
//   BubbleW                  force a bubble into MEM/WB
//   MemErr                   sticky timeout flag
module mem_stage_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       ResultSrcM,
    input  logic             MemWriteM,
    input  logic [WIDTH-1:0] ALURESULTM,
    input  logic [WIDTH-1:0] WriteDataM,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_gnt,
    input  logic             dmem_rvalid,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic [WIDTH-1:0] ReadDataM,
    output logic             StallMem,
    output logic             BubbleW,
    output logic             MemErr
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW:0] TO_LIM = (CW + 1)'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             access;
    logic [CW:0]      cnt_inc;
    logic             timeout_hit;

    // A load and a store flagged together is handled as a store.
    assign access  = MemWriteM | (ResultSrcM == 2'b01);

    // One extra bit so the comparison cannot wrap when the counter is at its top value.
    assign cnt_inc     = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc >= TO_LIM);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        dmem_req   = 1'b0;
        StallMem   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (access) begin
                    // Stall is combinational so the front end freezes in the
                    // same cycle the access first shows up in EX/MEM.
                    StallMem = 1'b1;
                    addr_d   = ALURESULTM;
                    wdata_d  = WriteDataM;
                    we_d     = MemWriteM;
                    cnt_d    = '0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                dmem_req = 1'b1;
                StallMem = 1'b1;
                cnt_d    = cnt_inc[CW-1:0];
                if (dmem_gnt) begin
                    if (we_q) begin
                        state_d = S_DONE;
                    end else if (dmem_rvalid) begin
                        rdata_d = dmem_rdata;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                StallMem = 1'b1;
                cnt_d    = cnt_inc[CW-1:0];
                if (dmem_rvalid) begin
                    rdata_d = dmem_rdata;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Stall released for one cycle so EX/MEM and MEM/WB advance;
                // a following access is picked up in IDLE.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dmem_we    = dmem_req & we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign ReadDataM  = rdata_q;
    assign MemErr     = err_q;
    assign BubbleW    = StallMem;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [31:0] ALURESULTM;
    logic [31:0] WriteDataM;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    logic        req_a, we_a, stall_a, bub_a, err_a;
    logic [31:0] addr_a, wdata_a, rd_a;
    logic        req_b, we_b, stall_b, bub_b, err_b;
    logic [31:0] addr_b, wdata_b, rd_b;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mem_stage_ctrl #(.WIDTH(32), .TIMEOUT(255)) u_dut (
        .CLK(CLK), .RST(RST), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .ALURESULTM(ALURESULTM), .WriteDataM(WriteDataM),
        .dmem_req(req_a), .dmem_we(we_a), .dmem_addr(addr_a), .dmem_wdata(wdata_a),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .ReadDataM(rd_a), .StallMem(stall_a), .BubbleW(bub_a), .MemErr(err_a)
    );

    mem_stage_ctrl #(.WIDTH(32), .TIMEOUT(4)) u_dut_t4 (
        .CLK(CLK), .RST(RST), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .ALURESULTM(ALURESULTM), .WriteDataM(WriteDataM),
        .dmem_req(req_b), .dmem_we(we_b), .dmem_addr(addr_b), .dmem_wdata(wdata_b),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .ReadDataM(rd_b), .StallMem(stall_b), .BubbleW(bub_b), .MemErr(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        ResultSrcM  = 2'b00;
        MemWriteM   = 1'b0;
        ALURESULTM  = 32'h0;
        WriteDataM  = 32'h0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
    endtask

    initial begin
        logic exp_stall;

        // ---------------- reset ----------------
        RST = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        RST = 1'b0;
        settle();
        chk("rst_req",   req_a,   1'b0);
        chk("rst_we",    we_a,    1'b0);
        chk("rst_addr",  addr_a,  32'h0);
        chk("rst_wdata", wdata_a, 32'h0);
        chk("rst_rdata", rd_a,    32'h0);
        chk("rst_stall", stall_a, 1'b0);
        chk("rst_bub",   bub_a,   1'b0);
        chk("rst_err",   err_a,   1'b0);
        cyc();

        // ---------------- store, immediate gnt ----------------
        MemWriteM  = 1'b1;
        ALURESULTM = 32'h0000_0100;
        WriteDataM = 32'hDEAD_BEEF;
        dmem_rvalid = 1'b1;            // rvalid in IDLE must be ignored
        dmem_rdata  = 32'h0BAD_0BAD;
        settle();
        chk("st_idle_stall", stall_a, 1'b1);
        chk("st_idle_req",   req_a,   1'b0);
        cyc();
        dmem_rvalid = 1'b0;
        dmem_gnt    = 1'b1;
        settle();
        chk("st_req_req",   req_a,   1'b1);
        chk("st_req_we",    we_a,    1'b1);
        chk("st_req_addr",  addr_a,  32'h0000_0100);
        chk("st_req_wdata", wdata_a, 32'hDEAD_BEEF);
        chk("st_req_stall", stall_a, 1'b1);
        cyc();
        dmem_gnt = 1'b0;
        settle();
        chk("st_done_stall", stall_a, 1'b0);
        chk("st_done_req",   req_a,   1'b0);
        chk("st_done_we",    we_a,    1'b0);
        chk("st_done_rdata", rd_a,    32'h0);
        cyc();
        idle_inputs();
        settle();
        chk("st_after_stall", stall_a, 1'b0);

        // ---------------- load, gnt on 3rd REQ cycle, rvalid 3 cycles later ----------------
        ResultSrcM = 2'b01;
        ALURESULTM = 32'h0000_0200;
        for (int k = 0; k <= 7; k++) begin
            dmem_gnt    = (k == 3);
            dmem_rvalid = (k == 1) || (k == 6) || (k == 7);
            dmem_rdata  = (k == 6) ? 32'h1234_5678 : 32'hFFFF_0000;
            settle();
            exp_stall = (k <= 6);
            chk($sformatf("ld_stall_k%0d", k), stall_a, exp_stall);
            chk($sformatf("ld_bub_k%0d", k),   bub_a,   exp_stall);
            if (k == 1) begin
                chk("ld_req",  req_a,  1'b1);
                chk("ld_we",   we_a,   1'b0);
                chk("ld_addr", addr_a, 32'h0000_0200);
            end
            if (k == 4) chk("ld_wait_req", req_a, 1'b0);
            if (k == 7) chk("ld_done_rdata", rd_a, 32'h1234_5678);
            cyc();
        end
        idle_inputs();
        settle();
        chk("ld_hold_rdata", rd_a,    32'h1234_5678);
        chk("ld_hold_stall", stall_a, 1'b0);
        cyc();

        // ---------------- back-to-back load then store ----------------
        ResultSrcM = 2'b01;
        ALURESULTM = 32'h0000_0300;
        settle();
        chk("b2b_ld_idle_stall", stall_a, 1'b1);
        cyc();
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_F00D;
        settle();
        chk("b2b_ld_req",  req_a,  1'b1);
        chk("b2b_ld_we",   we_a,   1'b0);
        chk("b2b_ld_addr", addr_a, 32'h0000_0300);
        cyc();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        settle();
        chk("b2b_ld_done_stall", stall_a, 1'b0);
        chk("b2b_ld_done_rdata", rd_a,    32'hCAFE_F00D);
        cyc();
        // Both load and store flags set: handled as a store.
        ResultSrcM = 2'b01;
        MemWriteM  = 1'b1;
        ALURESULTM = 32'h0000_0400;
        WriteDataM = 32'h55AA_55AA;
        settle();
        chk("b2b_st_idle_stall", stall_a, 1'b1);
        cyc();
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h7777_7777;
        settle();
        chk("b2b_st_req",   req_a,   1'b1);
        chk("b2b_st_we",    we_a,    1'b1);
        chk("b2b_st_addr",  addr_a,  32'h0000_0400);
        chk("b2b_st_wdata", wdata_a, 32'h55AA_55AA);
        cyc();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        settle();
        chk("b2b_st_done_stall", stall_a, 1'b0);
        chk("b2b_st_done_rdata", rd_a,    32'hCAFE_F00D);
        cyc();
        idle_inputs();

        // ---------------- timeout (TIMEOUT=4 instance) ----------------
        RST = 1'b1;
        cyc();
        cyc();
        RST = 1'b0;
        settle();
        chk("to_rst_err", err_b, 1'b0);
        // Successful load first so the timeout clearing ReadDataM is visible.
        ResultSrcM = 2'b01;
        ALURESULTM = 32'h0000_0500;
        cyc();
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hA5A5_A5A5;
        cyc();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        settle();
        chk("to_pre_rdata", rd_b, 32'hA5A5_A5A5);
        cyc();
        ALURESULTM = 32'h0000_0600;
        settle();
        chk("to_idle_stall", stall_b, 1'b1);
        cyc();
        for (int k = 1; k <= 4; k++) begin
            settle();
            chk($sformatf("to_req_k%0d", k),   req_b,   1'b1);
            chk($sformatf("to_stall_k%0d", k), stall_b, 1'b1);
            chk($sformatf("to_err_k%0d", k),   err_b,   1'b0);
            cyc();
        end
        settle();
        chk("to_done_err",   err_b,   1'b1);
        chk("to_done_req",   req_b,   1'b0);
        chk("to_done_stall", stall_b, 1'b0);
        chk("to_done_rdata", rd_b,    32'h0);
        cyc();
        idle_inputs();
        settle();
        chk("to_sticky1", err_b, 1'b1);
        cyc();
        settle();
        chk("to_sticky2", err_b, 1'b1);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        settle();
        chk("to_err_clr", err_b, 1'b0);
        cyc();

        // ---------------- reset during WAIT ----------------
        ResultSrcM = 2'b01;
        ALURESULTM = 32'h0000_0700;
        cyc();
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_2222;
        cyc();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        settle();
        chk("rw_pre_rdata", rd_a, 32'h1111_2222);
        cyc();
        ALURESULTM = 32'h0000_0800;
        cyc();
        dmem_gnt = 1'b1;
        settle();
        chk("rw_req", req_a, 1'b1);
        cyc();
        dmem_gnt = 1'b0;
        settle();
        chk("rw_wait_stall", stall_a, 1'b1);
        RST        = 1'b1;
        ResultSrcM = 2'b00;
        cyc();
        RST         = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h9999_9999;
        settle();
        chk("rw_req_after",   req_a,   1'b0);
        chk("rw_stall_after", stall_a, 1'b0);
        chk("rw_rdata_after", rd_a,    32'h0);
        cyc();
        dmem_rvalid = 1'b0;
        settle();
        chk("rw_late_rvalid", rd_a, 32'h0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
